// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle control FSM: state codes, opcodes,
// ALUOp codes and ALU B-input select codes.
package ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WRITE = 4'd6,
        EXEC_R    = 4'd7,
        EXEC_I    = 4'd8,
        ALU_WB    = 4'd9,
        BRANCH    = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    // States that hold a memory request open and are therefore timed.
    function automatic logic waits_on_mem(input state_t s);
        return (s == FETCH) || (s == MEM_READ) || (s == MEM_WRITE);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts MemReady-low cycles while a memory request is open and flags the
// cycle on which the stall budget is exhausted.
module mem_wait_timer #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic MemReady,
    output logic expired
);

    logic [CNT_W-1:0] count_reg;

    // A completing handshake or an abort always leaves the current state,
    // so both restart the count alongside leaving the timed states.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (!active || MemReady || expired) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = active && !MemReady && (count_reg == CNT_W'(WAIT_MAX));

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle datapath: sequences fetch/decode/execute/
// memory/write-back and drives every datapath enable and mux select.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] Opcode,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       PCSource,
    output logic       IllegalOp,
    output logic       MemTimeout,
    output logic [3:0] State
);

    state_t state_reg;
    logic   mem_active;
    logic   expired;
    logic   opcode_legal;

    assign mem_active   = waits_on_mem(state_reg);
    assign opcode_legal = (Opcode == OP_LOAD)  || (Opcode == OP_STORE) ||
                          (Opcode == OP_RTYPE) || (Opcode == OP_ITYPE) ||
                          (Opcode == OP_BRANCH);

    mem_wait_timer #(
        .WAIT_MAX(WAIT_MAX),
        .CNT_W   (CNT_W)
    ) u_wait (
        .clk     (clk),
        .reset   (reset),
        .active  (mem_active),
        .MemReady(MemReady),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            case (state_reg)
                IDLE:      state_reg <= FETCH;
                FETCH: begin
                    if (MemReady)     state_reg <= DECODE;
                    else if (expired) state_reg <= FETCH;
                end
                DECODE: begin
                    case (Opcode)
                        OP_LOAD, OP_STORE: state_reg <= MEM_ADDR;
                        OP_RTYPE:          state_reg <= EXEC_R;
                        OP_ITYPE:          state_reg <= EXEC_I;
                        OP_BRANCH:         state_reg <= BRANCH;
                        default:           state_reg <= FETCH;
                    endcase
                end
                MEM_ADDR:  state_reg <= (Opcode == OP_LOAD) ? MEM_READ : MEM_WRITE;
                MEM_READ: begin
                    if (MemReady)     state_reg <= MEM_WB;
                    else if (expired) state_reg <= FETCH;
                end
                MEM_WRITE: begin
                    if (MemReady || expired) state_reg <= FETCH;
                end
                EXEC_R:    state_reg <= ALU_WB;
                EXEC_I:    state_reg <= ALU_WB;
                MEM_WB:    state_reg <= FETCH;
                ALU_WB:    state_reg <= FETCH;
                BRANCH:    state_reg <= FETCH;
                default:   state_reg <= FETCH;
            endcase
        end
    end

    // Outputs follow the state register; only the FETCH load strobes and the
    // two exception pulses look at the current inputs.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_RS2;
        ALUOp       = ALUOP_ADD;
        PCSource    = 1'b0;
        IllegalOp   = 1'b0;
        MemTimeout  = expired;
        State       = state_reg;
        case (state_reg)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            DECODE: begin
                ALUSrcB   = SRCB_BOFF;
                IllegalOp = !opcode_legal;
            end
            MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            MEM_READ: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            MEM_WRITE: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_IMM;
            end
            ALU_WB: begin
                RegWrite = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: each instruction is expanded into an
// expected per-cycle trace from the sequencing rules, then replayed against the DUT.
module tb_multicycle_control;
    import ctrl_pkg::*;

    localparam int WAIT_MAX = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] Opcode;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegWrite, ALUSrcA, PCSource, IllegalOp, MemTimeout;
    logic [1:0] ALUSrcB, ALUOp;
    logic [3:0] State;

    always #5 clk = ~clk;

    multicycle_control #(.WAIT_MAX(WAIT_MAX), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
        .IllegalOp(IllegalOp), .MemTimeout(MemTimeout), .State(State)
    );

    typedef struct packed {
        logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, srca;
        logic [1:0] srcb, aluop;
        logic       pcsrc, ill, tmo;
    } outs_t;

    typedef struct {
        logic       mr;
        logic [6:0] op;
        logic [3:0] st;
        outs_t      o;
    } step_t;

    outs_t      got;
    step_t      q[$];
    logic [6:0] cur_op;
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;

    assign got = '{PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                   RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalOp, MemTimeout};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input state_t st, input logic mr, input outs_t o);
        step_t s;
        s.mr = mr; s.op = cur_op; s.st = 4'(st); s.o = o;
        q.push_back(s);
    endtask

    function automatic int rand_wait();
        int r = int'($urandom_range(0, 9));
        if (r <= 5) return 0;
        if (r <= 7) return int'($urandom_range(1, 3));
        if (r == 8) return int'($urandom_range(15, 16));
        return int'($urandom_range(14, 20));
    endfunction

    // One memory handshake of w ready-low cycles; aborts on the 16th low cycle.
    task automatic gen_handshake(input state_t st, input int w, input outs_t base,
                                 output bit ok);
        outs_t o;
        ok = 1'b0;
        for (int i = 0; i <= WAIT_MAX; i++) begin
            o = base;
            if (i == w) begin
                if (st == FETCH) begin o.irw = 1'b1; o.pcw = 1'b1; end
                push(st, 1'b1, o);
                ok = 1'b1;
                break;
            end
            if (i == WAIT_MAX) o.tmo = 1'b1;
            push(st, 1'b0, o);
        end
    endtask

    task automatic gen_instr(input logic [6:0] op, input int fw, input int mw);
        outs_t o;
        bit    ok;
        int    w;
        cur_op = op;
        o = '0; o.mrd = 1'b1; o.srcb = 2'b01;
        w = (fw < 0) ? rand_wait() : fw;
        gen_handshake(FETCH, w, o, ok);
        while (!ok) gen_handshake(FETCH, 0, o, ok);
        o = '0; o.srcb = 2'b11;
        if (!(op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011}))
            o.ill = 1'b1;
        push(DECODE, 1'b1, o);
        w = (mw < 0) ? rand_wait() : mw;
        case (op)
            7'b0000011, 7'b0100011: begin
                o = '0; o.srca = 1'b1; o.srcb = 2'b10;
                push(MEM_ADDR, 1'b1, o);
                o = '0; o.iord = 1'b1;
                if (op == 7'b0000011) begin
                    o.mrd = 1'b1;
                    gen_handshake(MEM_READ, w, o, ok);
                    if (ok) begin
                        o = '0; o.rw = 1'b1; o.m2r = 1'b1;
                        push(MEM_WB, 1'b1, o);
                    end
                end else begin
                    o.mwr = 1'b1;
                    gen_handshake(MEM_WRITE, w, o, ok);
                end
            end
            7'b0110011: begin
                o = '0; o.srca = 1'b1; o.aluop = 2'b10;
                push(EXEC_R, 1'b1, o);
                o = '0; o.rw = 1'b1;
                push(ALU_WB, 1'b1, o);
            end
            7'b0010011: begin
                o = '0; o.srca = 1'b1; o.srcb = 2'b10; o.aluop = 2'b11;
                push(EXEC_I, 1'b1, o);
                o = '0; o.rw = 1'b1;
                push(ALU_WB, 1'b1, o);
            end
            7'b1100011: begin
                o = '0; o.srca = 1'b1; o.aluop = 2'b01; o.pcwc = 1'b1; o.pcsrc = 1'b1;
                push(BRANCH, 1'b1, o);
            end
            default: ;
        endcase
    endtask

    task automatic run_steps(input int n);
        step_t s;
        for (int i = 0; i < n && q.size() > 0; i++) begin
            s = q.pop_front();
            @(negedge clk);
            MemReady = s.mr;
            Opcode   = s.op;
            #1;
            cyc++;
            check($sformatf("cyc%0d state", cyc), 32'(State), 32'(s.st));
            check($sformatf("cyc%0d outs st=%0d", cyc, s.st), 32'(got), 32'(s.o));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] ops[5];
        logic [6:0] op;
        ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
        ops[3] = 7'b0010011; ops[4] = 7'b1100011;
        reset = 1'b1; MemReady = 1'b0; Opcode = '0; cur_op = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset state", 32'(State), 32'(IDLE));
        check("reset outs", 32'(got), 32'd0);
        @(posedge clk);
        #2 reset = 1'b0;

        push(IDLE, 1'b0, outs_t'('0));
        gen_instr(7'b0000011, 0, 0);
        gen_instr(7'b0100011, 0, 3);
        gen_instr(7'b0110011, 0, 0);
        gen_instr(7'b0010011, 0, 0);
        gen_instr(7'b1100011, 0, 0);
        gen_instr(7'b1111111, 0, 0);
        gen_instr(7'b0110011, 16, 0);
        gen_instr(7'b0110011, 15, 0);
        gen_instr(7'b0000011, 0, 16);
        gen_instr(7'b0000011, 0, 15);
        gen_instr(7'b0100011, 0, 16);
        run_steps(q.size());

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 5) == 0) op = 7'($urandom);
            else op = ops[$urandom_range(0, 4)];
            gen_instr(op, -1, -1);
            run_steps(q.size());
        end

        // Asynchronous reset in the middle of a stalled load.
        gen_instr(7'b0000011, 0, 10);
        run_steps(6);
        #3 reset = 1'b1;
        #1;
        check("async reset state", 32'(State), 32'(IDLE));
        check("async reset outs", 32'(got), 32'd0);
        q.delete();
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("after release state", 32'(State), 32'(IDLE));
        @(posedge clk);
        #1;
        check("refetch state", 32'(State), 32'(FETCH));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle datapath. It is the producer side of the 2-bit ALUOp interface consumed by the ALU control decoder.
- Sequences each instruction through fetch, decode, execute, memory and write-back. It drives all datapath enables and mux selects.
- It also runs a MemRead/MemWrite vs MemReady handshake with memory and has a stall timeout.

Parameters:
- WAIT_MAX, 15: MemReady-low cycles tolerated in one memory state before abort. Must be ≥1.
- CNT_W, 4: wait counter width. Must satisfy 2^CNT_W > WAIT_MAX.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- Opcode  in  7  IR[6:0], valid from DECODE onward
- MemReady  in  1  memory completes current read/write this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU Zero
- IorD  out  1  0=PC address, 1=ALUOut address
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  0=ALUOut, 1=MDR to register file
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0=PC, 1=rs1
- ALUSrcB  out  2  00=rs2, 01=const 4, 10=imm, 11=branch offset imm
- ALUOp  out  2  00=add (ld/sd/sb), 01=sub (beq), 10=use Funct (R-type), 11=immediate op
- PCSource  out  1  0=ALU result, 1=ALUOut
- IllegalOp  out  1  one-cycle pulse on unknown opcode
- MemTimeout  out  1  one-cycle pulse on handshake abort
- State  out  4  current state code, for debug

Behaviour:
- Reset asserted, asynchronous:
  - State=IDLE, wait counter=0.
  - Every output 0 except State.
- Output decode:
  - All outputs are Moore, decoded from state.
  - Exception: the FETCH IRWrite/PCWrite pulses and the IllegalOp/MemTimeout pulses are Mealy-gated as stated below.
  - Any signal not listed for a state is 0.
- IDLE:
  - All outputs 0.
  - Next cycle goes to FETCH unconditionally.
- FETCH:
  - Drives IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=0.
  - IRWrite=PCWrite=MemReady.
  - MemReady=1 -> DECODE. Otherwise stay.
- DECODE:
  - Drives ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut).
  - Next state by Opcode:
    - 0000011 (load) or 0100011 (store) -> MEM_ADDR
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 1100011 -> BRANCH
    - anything else -> IllegalOp=1 this cycle, then FETCH
- MEM_ADDR:
  - Drives ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Load -> MEM_READ. Store -> MEM_WRITE.
  - Opcode is held stable by the IR.
- MEM_READ:
  - Drives IorD=1, MemRead=1.
  - MemReady=1 -> MEM_WB. Otherwise stay.
- MEM_WB:
  - Drives RegWrite=1, MemtoReg=1, then -> FETCH.
- MEM_WRITE:
  - Drives IorD=1, MemWrite=1.
  - MemReady=1 -> FETCH. Otherwise stay.
- EXEC_R:
  - Drives ALUSrcA=1, ALUSrcB=00, ALUOp=10, then -> ALU_WB.
- EXEC_I:
  - Drives ALUSrcA=1, ALUSrcB=10, ALUOp=11, then -> ALU_WB.
- ALU_WB:
  - Drives RegWrite=1, MemtoReg=0, then -> FETCH.
- BRANCH:
  - Drives ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=1, then -> FETCH.
- Latencies, in cycles, with MemReady always high:
  - ld: 5
  - sd/sb: 4
  - R-type/I-type: 4
  - beq: 3
  - illegal: 2
- Wait counter:
  - Applies only in FETCH, MEM_READ and MEM_WRITE.
  - Increments each cycle MemReady=0. Clears on any state change.
  - When count==WAIT_MAX and MemReady=0: MemTimeout=1 this cycle, next state FETCH, counter cleared.
  - On abort, IRWrite, PCWrite and RegWrite stay 0. A FETCH timeout re-fetches the same PC.
- Simultaneous events:
  - MemReady=1 in the same cycle count reaches WAIT_MAX: completion wins, no MemTimeout.
- Unused state codes: recover to FETCH on the next clock, all outputs 0.
- Reset mid-instruction: immediate return to IDLE with outputs 0. The in-flight memory request is dropped with no completion.

Decomposition:
- Shared package ctrl_pkg:
  - state encodings: IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, BRANCH
  - opcode constants
  - ALUOp codes ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT, ALUOP_IMM
  - ALUSrcB select codes
- One sub-module, mem_wait_timer:
  - inputs: clk, reset, active, MemReady
  - output: expired
  - contains the counter and the WAIT_MAX compare.

Test Plan:
- Release reset, MemReady=1, Opcode=0000011:
  - states IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, FETCH.
  - IRWrite and PCWrite high only in the FETCH cycle; RegWrite+MemtoReg only in MEM_WB.
  - ALUOp=00 in MEM_ADDR.
- Opcode=0100011, MemReady low 3 cycles in MEM_WRITE then high:
  - MemWrite held 4 cycles, IorD=1 throughout, then FETCH, no MemTimeout.
- Opcode=0110011, then 0010011, then 1100011:
  - ALUOp 10 in EXEC_R, 11 in EXEC_I, 01 in BRANCH.
  - PCWriteCond=1 and PCSource=1 in BRANCH only.
  - Cycle counts 4, 4, 3.
- Opcode=1111111:
  - IllegalOp pulses exactly 1 cycle in DECODE, next state FETCH.
  - RegWrite and MemWrite never asserted.
- MemReady held 0 in FETCH with WAIT_MAX=15:
  - MemTimeout on the 16th FETCH cycle, IRWrite never 1, FETCH re-entered with counter 0.
  - Repeat with MemReady=1 on the 16th cycle: DECODE, no MemTimeout.
- Assert reset for 1 cycle mid-MEM_READ, asynchronously between edges:
  - all outputs 0 immediately, State=IDLE; FETCH one cycle after reset release.
